fetch_queue: RTL and testbench

Instruction-bundle prefetch queue between the `mmu` instruction-fetch port and the core's issue logic. It owns the fetch PC and issues one bundle fetch at a time to the `mmu`. Returned bundles are buffered with their addresses in a small FIFO, and presented to the functional units through a valid/take handshake. A branch redirect flushes the queue and discards any in-flight fetch.

---
 rtl/fetch_queue.sv | 125 ++++++++++++
 tb/tb_fetch_queue.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-bundle prefetch queue. Owns the fetch PC, keeps at
// most one bundle fetch outstanding at the mmu, buffers returned bundles with
// their addresses in a DEPTH-entry FIFO, and flushes everything on a redirect.
module fetch_queue #(
  parameter int          NFU      = 2,
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [63:0]                fetchAddress,
  output logic                       doFetch,
  input  logic                       doneFetch,
  input  logic [NFU*32-1:0]          fetchData,
  input  logic                       redirectValid,
  input  logic [63:0]                redirectAddr,
  output logic                       bundleValid,
  output logic [NFU*32-1:0]          bundle,
  output logic [63:0]                bundleAddr,
  input  logic                       bundleTake,
  output logic [$clog2(DEPTH):0]     queueCount
);

  localparam int BW   = NFU * 32;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int STEP = NFU * 4;
  localparam int OFFB = $clog2(STEP);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t          r_state;
  logic [63:0]     r_pc;
  logic [63:0]     r_fetch_addr;
  logic            r_do_fetch;
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [BW-1:0]   r_mem_data [DEPTH];
  logic [63:0]     r_mem_addr [DEPTH];

  logic            w_push;
  logic            w_pop;
  logic            w_space;
  logic [63:0]     w_redir_pc;

  // A push only happens for a fetch that is still wanted; a redirect on the
  // same edge wins over both the returning data and any pop.
  assign w_push     = (r_state == S_WAIT) && doneFetch && !redirectValid;
  assign w_pop      = (r_count != '0) && bundleTake && !redirectValid;
  assign w_space    = (r_count != CW'(DEPTH));
  assign w_redir_pc = redirectAddr & ~((64'(1) << OFFB) - 64'(1));

  assign fetchAddress = r_fetch_addr;
  assign doFetch      = r_do_fetch;
  assign bundleValid  = (r_count != '0);
  assign bundle       = r_mem_data[r_head];
  assign bundleAddr   = r_mem_addr[r_head];
  assign queueCount   = r_count;

  // Fetch FSM: one outstanding request; DISCARD swallows a response made stale
  // by a redirect. Space is checked at issue time, so a later push never overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_fetch_addr <= RESET_PC;
      r_do_fetch   <= 1'b0;
    end else begin
      r_do_fetch <= 1'b0;
      if (redirectValid) begin
        r_pc <= w_redir_pc;
        case (r_state)
          S_WAIT:    r_state <= doneFetch ? S_IDLE : S_DISCARD;
          S_DISCARD: if (doneFetch) r_state <= S_IDLE;
          default:   r_state <= S_IDLE;
        endcase
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_space) begin
              r_do_fetch   <= 1'b1;
              r_fetch_addr <= r_pc;
              r_state      <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (doneFetch) begin
              r_pc    <= r_pc + 64'(STEP);
              r_state <= S_IDLE;
            end
          end
          S_DISCARD: if (doneFetch) r_state <= S_IDLE;
          default:   r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Pointer and occupancy bookkeeping; a redirect empties the queue.
  always_ff @(posedge clk) begin
    if (rst || redirectValid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents only matter while counted as valid, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_tail] <= fetchData;
      r_mem_addr[r_tail] <= r_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a small mmu responder plus manual overrides,
// and one task per scenario with inline checks.
module tb_fetch_queue;

  localparam logic [63:0] RPC2 = 64'hFFFF_FFFF_FFFF_FFF8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   fetchAddress;
  logic          doFetch;
  logic          doneFetch;
  logic [63:0]   fetchData;
  logic          redirectValid = 1'b0;
  logic [63:0]   redirectAddr = '0;
  logic          bundleValid;
  logic [63:0]   bundle;
  logic [63:0]   bundleAddr;
  logic          bundleTake = 1'b0;
  logic [2:0]    queueCount;

  logic          mmu_en = 1'b0;
  int            mmu_lat = 1;
  logic          mmu_done = 1'b0;
  logic [63:0]   mmu_data = '0;
  logic          man_done = 1'b0;
  logic [63:0]   man_data = '0;

  assign doneFetch = mmu_done | man_done;
  assign fetchData = mmu_done ? mmu_data : man_data;

  // second instance for wrap-around and mid-fetch reset
  logic          rst2 = 1'b1;
  logic [63:0]   fetchAddress2;
  logic          doFetch2;
  logic          done2 = 1'b0;
  logic [63:0]   data2 = '0;
  logic          bundleValid2;
  logic [63:0]   bundle2;
  logic [63:0]   bundleAddr2;
  logic [2:0]    queueCount2;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.NFU(2), .DEPTH(4), .RESET_PC(64'h0)) u1 (
    .clk(clk), .rst(rst), .fetchAddress(fetchAddress), .doFetch(doFetch),
    .doneFetch(doneFetch), .fetchData(fetchData), .redirectValid(redirectValid),
    .redirectAddr(redirectAddr), .bundleValid(bundleValid), .bundle(bundle),
    .bundleAddr(bundleAddr), .bundleTake(bundleTake), .queueCount(queueCount)
  );

  fetch_queue #(.NFU(2), .DEPTH(4), .RESET_PC(RPC2)) u2 (
    .clk(clk), .rst(rst2), .fetchAddress(fetchAddress2), .doFetch(doFetch2),
    .doneFetch(done2), .fetchData(data2), .redirectValid(1'b0),
    .redirectAddr(64'h0), .bundleValid(bundleValid2), .bundle(bundle2),
    .bundleAddr(bundleAddr2), .bundleTake(1'b0), .queueCount(queueCount2)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] tagf(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_0000, a[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mmu model: answer each accepted request after mmu_lat cycles
  initial begin
    logic [63:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (mmu_en && doFetch) begin
        a = fetchAddress;
        repeat (mmu_lat) @(posedge clk);
        #1;
        mmu_data = tagf(a);
        mmu_done = 1'b1;
        @(posedge clk);
        #1;
        mmu_done = 1'b0;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (doFetch !== 1'b0) begin bad++; $display("FAIL reset_doFetch got %0b exp 0", doFetch); end
    total++; if (fetchAddress !== 64'h0) begin bad++; $display("FAIL reset_fetchAddress got %h exp 0", fetchAddress); end
    total++; if (bundleValid !== 1'b0) begin bad++; $display("FAIL reset_bundleValid got %0b exp 0", bundleValid); end
    total++; if (queueCount !== 3'd0) begin bad++; $display("FAIL reset_queueCount got %0d exp 0", queueCount); end
    mmu_lat = 1;
    mmu_en  = 1'b1;
    rst     = 1'b0;
  endtask

  task automatic test_fill();
    int n = 0;
    int last = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (doFetch) begin
        if (n < 4) begin
          total++;
          if (fetchAddress !== 64'(n * 8)) begin
            bad++; $display("FAIL fill_addr[%0d] got %h exp %h", n, fetchAddress, 64'(n * 8));
          end
          if (n > 0) begin
            total++;
            if (c - last != 3) begin bad++; $display("FAIL fill_cadence got %0d exp 3", c - last); end
          end
        end
        last = c;
        n++;
      end
    end
    total++; if (n != 4) begin bad++; $display("FAIL fill_fetch_count got %0d exp 4", n); end
    total++; if (queueCount !== 3'd4) begin bad++; $display("FAIL fill_queueCount got %0d exp 4", queueCount); end
    total++; if (bundleAddr !== 64'h0) begin bad++; $display("FAIL fill_head_addr got %h exp 0", bundleAddr); end
    total++; if (bundle !== tagf(64'h0)) begin bad++; $display("FAIL fill_head_data got %h exp %h", bundle, tagf(64'h0)); end
  endtask

  task automatic test_take_full();
    bundleTake = 1'b1;
    tick();
    bundleTake = 1'b0;
    total++; if (bundleAddr !== 64'h8) begin bad++; $display("FAIL take_head_addr got %h exp 8", bundleAddr); end
    total++; if (queueCount !== 3'd3) begin bad++; $display("FAIL take_queueCount got %0d exp 3", queueCount); end
    total++; if (doFetch !== 1'b0) begin bad++; $display("FAIL take_early_fetch got %0b exp 0", doFetch); end
    tick();
    total++; if (doFetch !== 1'b1) begin bad++; $display("FAIL take_refetch got %0b exp 1", doFetch); end
    total++; if (fetchAddress !== 64'h20) begin bad++; $display("FAIL take_refetch_addr got %h exp 20", fetchAddress); end
    tick();
    tick();
    total++; if (queueCount !== 3'd4) begin bad++; $display("FAIL take_refill got %0d exp 4", queueCount); end
  endtask

  task automatic test_stream();
    logic [63:0] expd = 64'h8;
    logic pair = 1'b0;
    for (int c = 0; c < 300 && expd < 64'h50; c++) begin
      #1;
      if (pair) begin
        total++;
        if (queueCount !== 3'd2) begin bad++; $display("FAIL stream_pushpop_count got %0d exp 2", queueCount); end
      end
      if (bundleValid && (queueCount > 3'd2 || (queueCount == 3'd2 && doneFetch))) begin
        total++;
        if (bundleAddr !== expd) begin bad++; $display("FAIL stream_order got %h exp %h", bundleAddr, expd); end
        total++;
        if (bundle !== tagf(expd)) begin bad++; $display("FAIL stream_data got %h exp %h", bundle, tagf(expd)); end
        pair = (queueCount == 3'd2) && doneFetch;
        expd = expd + 64'h8;
        bundleTake = 1'b1;
      end else begin
        pair = 1'b0;
        bundleTake = 1'b0;
      end
      tick();
    end
    bundleTake = 1'b0;
    #1;
    if (pair) begin
      total++;
      if (queueCount !== 3'd2) begin bad++; $display("FAIL stream_pushpop_count got %0d exp 2", queueCount); end
    end
    total++; if (expd !== 64'h50) begin bad++; $display("FAIL stream_timeout got %h exp 50", expd); end
  endtask

  task automatic test_redirect_wait();
    logic seen = 1'b0;
    logic [63:0] held;
    mmu_en = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      seen = doFetch;
    end
    total++; if (!seen) begin bad++; $display("FAIL rdw_wait_fetch got 0 exp 1"); end
    held = fetchAddress;
    tick();
    total++; if (fetchAddress !== held) begin bad++; $display("FAIL rdw_addr_stable got %h exp %h", fetchAddress, held); end
    redirectValid = 1'b1;
    redirectAddr  = 64'h1005;
    tick();
    redirectValid = 1'b0;
    total++; if (queueCount !== 3'd0) begin bad++; $display("FAIL rdw_flush_count got %0d exp 0", queueCount); end
    total++; if (bundleValid !== 1'b0) begin bad++; $display("FAIL rdw_flush_valid got %0b exp 0", bundleValid); end
    total++; if (doFetch !== 1'b0) begin bad++; $display("FAIL rdw_no_fetch got %0b exp 0", doFetch); end
    tick();
    tick();
    man_data = 64'hDEAD_BEEF_DEAD_BEEF;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    total++; if (queueCount !== 3'd0) begin bad++; $display("FAIL rdw_late_drop got %0d exp 0", queueCount); end
    tick();
    total++; if (doFetch !== 1'b1) begin bad++; $display("FAIL rdw_target_fetch got %0b exp 1", doFetch); end
    total++; if (fetchAddress !== 64'h1000) begin bad++; $display("FAIL rdw_target_addr got %h exp 1000", fetchAddress); end
    tick();
    man_data = tagf(64'h1000);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    total++; if (queueCount !== 3'd1) begin bad++; $display("FAIL rdw_push_count got %0d exp 1", queueCount); end
    total++; if (bundleAddr !== 64'h1000) begin bad++; $display("FAIL rdw_head_addr got %h exp 1000", bundleAddr); end
    total++; if (bundle !== tagf(64'h1000)) begin bad++; $display("FAIL rdw_head_data got %h exp %h", bundle, tagf(64'h1000)); end
  endtask

  task automatic test_redirect_done_take();
    tick();
    total++; if (doFetch !== 1'b1) begin bad++; $display("FAIL rdd_fetch got %0b exp 1", doFetch); end
    total++; if (fetchAddress !== 64'h1008) begin bad++; $display("FAIL rdd_fetch_addr got %h exp 1008", fetchAddress); end
    tick();
    man_data      = tagf(64'h1008);
    man_done      = 1'b1;
    redirectValid = 1'b1;
    redirectAddr  = 64'h2000;
    bundleTake    = 1'b1;
    tick();
    man_done      = 1'b0;
    redirectValid = 1'b0;
    bundleTake    = 1'b0;
    total++; if (queueCount !== 3'd0) begin bad++; $display("FAIL rdd_count got %0d exp 0", queueCount); end
    total++; if (bundleValid !== 1'b0) begin bad++; $display("FAIL rdd_valid got %0b exp 0", bundleValid); end
    total++; if (doFetch !== 1'b0) begin bad++; $display("FAIL rdd_no_fetch got %0b exp 0", doFetch); end
    tick();
    total++; if (doFetch !== 1'b1) begin bad++; $display("FAIL rdd_target_fetch got %0b exp 1", doFetch); end
    total++; if (fetchAddress !== 64'h2000) begin bad++; $display("FAIL rdd_target_addr got %h exp 2000", fetchAddress); end
    tick();
    man_data = tagf(64'h2000);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    total++; if (queueCount !== 3'd1) begin bad++; $display("FAIL rdd_push_count got %0d exp 1", queueCount); end
    total++; if (bundleAddr !== 64'h2000) begin bad++; $display("FAIL rdd_head_addr got %h exp 2000", bundleAddr); end
  endtask

  task automatic test_wrap_reset();
    total++; if (fetchAddress2 !== RPC2) begin bad++; $display("FAIL wrap_reset_addr got %h exp %h", fetchAddress2, RPC2); end
    total++; if (queueCount2 !== 3'd0) begin bad++; $display("FAIL wrap_reset_count got %0d exp 0", queueCount2); end
    rst2 = 1'b0;
    tick();
    total++; if (doFetch2 !== 1'b1) begin bad++; $display("FAIL wrap_fetch1 got %0b exp 1", doFetch2); end
    total++; if (fetchAddress2 !== RPC2) begin bad++; $display("FAIL wrap_addr1 got %h exp %h", fetchAddress2, RPC2); end
    tick();
    data2 = tagf(RPC2);
    done2 = 1'b1;
    tick();
    done2 = 1'b0;
    total++; if (queueCount2 !== 3'd1) begin bad++; $display("FAIL wrap_push got %0d exp 1", queueCount2); end
    total++; if (bundleAddr2 !== RPC2) begin bad++; $display("FAIL wrap_head_addr got %h exp %h", bundleAddr2, RPC2); end
    tick();
    total++; if (doFetch2 !== 1'b1) begin bad++; $display("FAIL wrap_fetch2 got %0b exp 1", doFetch2); end
    total++; if (fetchAddress2 !== 64'h0) begin bad++; $display("FAIL wrap_addr2 got %h exp 0", fetchAddress2); end
    tick();
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    total++; if (doFetch2 !== 1'b0) begin bad++; $display("FAIL rstmid_doFetch got %0b exp 0", doFetch2); end
    total++; if (fetchAddress2 !== RPC2) begin bad++; $display("FAIL rstmid_addr got %h exp %h", fetchAddress2, RPC2); end
    total++; if (bundleValid2 !== 1'b0) begin bad++; $display("FAIL rstmid_valid got %0b exp 0", bundleValid2); end
    total++; if (queueCount2 !== 3'd0) begin bad++; $display("FAIL rstmid_count got %0d exp 0", queueCount2); end
    data2 = tagf(64'h0);
    done2 = 1'b1;
    tick();
    done2 = 1'b0;
    total++; if (queueCount2 !== 3'd0) begin bad++; $display("FAIL rstmid_trailing got %0d exp 0", queueCount2); end
    total++; if (doFetch2 !== 1'b1) begin bad++; $display("FAIL rstmid_refetch got %0b exp 1", doFetch2); end
    total++; if (fetchAddress2 !== RPC2) begin bad++; $display("FAIL rstmid_refetch_addr got %h exp %h", fetchAddress2, RPC2); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_take_full();
    test_stream();
    test_redirect_wait();
    test_redirect_done_take();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
